// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: sequences the bias/partial-sum accumulator of one
// convolution unit. Counts conv results in raster order per input channel,
// selects bias (channel 0) or stored partial sum (later channels), and issues
// partial-sum buffer reads plus writes delayed to match the adder latency.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               begin one accumulation pass (honoured only in IDLE)
//   conv_valid          conv result present this cycle
//   accu_enable         0 = add bias, 1 = add stored partial sum
//   rd_en, rd_addr      partial-sum buffer read strobe / address
//   wr_en, wr_addr      partial-sum buffer write strobe / address
//   wr_last_pass        write belongs to the final channel
//   channel_idx         channel currently accumulated
//   busy                high while running or flushing
//   done                one-cycle pulse after the last write is issued
module accumulator_sequencer #(
  parameter int unsigned IFM_SIZE_NEXT           = 10,
  parameter int unsigned IFM_DEPTH               = 3,
  parameter int unsigned ADDER_LATENCY           = 1,
  parameter int unsigned ADDRESS_SIZE_NEXT_IFM   = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int unsigned NUMBER_OF_BITS_CHANNELS = $clog2(IFM_DEPTH) + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               conv_valid,
  output logic                               accu_enable,
  output logic                               rd_en,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]   rd_addr,
  output logic                               wr_en,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]   wr_addr,
  output logic                               wr_last_pass,
  output logic [NUMBER_OF_BITS_CHANNELS-1:0] channel_idx,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned OFM_PIXELS = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
  localparam int unsigned AW         = ADDRESS_SIZE_NEXT_IFM;
  localparam int unsigned CW         = NUMBER_OF_BITS_CHANNELS;
  localparam int unsigned FW         = 3;

  localparam logic [AW-1:0] LAST_PIX   = AW'(OFM_PIXELS - 1);
  localparam logic [CW-1:0] LAST_CH    = CW'(IFM_DEPTH - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ADDER_LATENCY - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pixel_q, pixel_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [FW-1:0] flush_q, flush_d;

  logic in_vld;
  logic in_last;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pixel_q <= '0;
      chan_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      pixel_q <= pixel_d;
      chan_q  <= chan_d;
      flush_q <= flush_d;
    end
  end

  // Next-state and counter logic; counters hold on cycles without conv_valid
  always_comb begin
    state_d = state_q;
    pixel_d = pixel_q;
    chan_d  = chan_q;
    flush_d = flush_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pixel_d = '0;
          chan_d  = '0;
        end
      end
      S_RUN: begin
        if (conv_valid) begin
          if (pixel_q == LAST_PIX) begin
            pixel_d = '0;
            if (chan_q == LAST_CH) begin
              chan_d  = '0;
              flush_d = '0;
              // Zero-latency adder needs no drain cycles
              state_d = (ADDER_LATENCY == 0) ? S_DONE : S_FLUSH;
            end else begin
              chan_d = chan_q + CW'(1);
            end
          end else begin
            pixel_d = pixel_q + AW'(1);
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FLUSH_LAST) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read side and status outputs follow the current state directly
  assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done        = (state_q == S_DONE);
  assign accu_enable = (state_q == S_RUN) && (chan_q != '0);
  assign rd_en       = (state_q == S_RUN) && conv_valid && (chan_q != '0);
  assign rd_addr     = (state_q == S_RUN) ? pixel_q : '0;
  assign channel_idx = chan_q;

  assign in_vld  = (state_q == S_RUN) && conv_valid;
  assign in_last = (chan_q == LAST_CH);

  // Write delay chain: free-running, never stalls, cleared by reset
  if (ADDER_LATENCY == 0) begin : g_no_pipe
    assign wr_en        = in_vld;
    assign wr_addr      = pixel_q;
    assign wr_last_pass = in_vld & in_last;
  end else begin : g_pipe
    logic [ADDER_LATENCY-1:0] vld_q;
    logic [ADDER_LATENCY-1:0] last_q;
    logic [AW-1:0]            addr_q [ADDER_LATENCY];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q  <= '0;
        last_q <= '0;
        for (int i = 0; i < int'(ADDER_LATENCY); i++) begin
          addr_q[i] <= '0;
        end
      end else begin
        vld_q[0]  <= in_vld;
        last_q[0] <= in_last;
        addr_q[0] <= pixel_q;
        for (int i = 1; i < int'(ADDER_LATENCY); i++) begin
          vld_q[i]  <= vld_q[i-1];
          last_q[i] <= last_q[i-1];
          addr_q[i] <= addr_q[i-1];
        end
      end
    end

    assign wr_en        = vld_q[ADDER_LATENCY-1];
    assign wr_addr      = addr_q[ADDER_LATENCY-1];
    assign wr_last_pass = vld_q[ADDER_LATENCY-1] & last_q[ADDER_LATENCY-1];
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer. Four instances with different
// parameter sets share one stimulus; `sel` picks which one is observed.
// Expected writes go into a scoreboard when a pulse is driven and are
// retired when the observed instance raises wr_en.
module tb_accumulator_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic conv_valid = 1'b0;
  int   cyc = 0;
  int   sel = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a: 10x10, 3 ch, lat 1
  logic a_accu, a_rd_en, a_wr_en, a_last, a_busy, a_done;
  logic [6:0] a_rd_addr, a_wr_addr;
  logic [2:0] a_ch;
  // dut_b: 2x2, 2 ch, lat 1
  logic b_accu, b_rd_en, b_wr_en, b_last, b_busy, b_done;
  logic [1:0] b_rd_addr, b_wr_addr;
  logic [1:0] b_ch;
  // dut_c: 10x10, 1 ch, lat 0
  logic c_accu, c_rd_en, c_wr_en, c_last, c_busy, c_done;
  logic [6:0] c_rd_addr, c_wr_addr;
  logic [0:0] c_ch;
  // dut_d: 10x10, 1 ch, lat 3
  logic d_accu, d_rd_en, d_wr_en, d_last, d_busy, d_done;
  logic [6:0] d_rd_addr, d_wr_addr;
  logic [0:0] d_ch;

  accumulator_sequencer #(.IFM_SIZE_NEXT(10), .IFM_DEPTH(3), .ADDER_LATENCY(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .conv_valid(conv_valid),
    .accu_enable(a_accu), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .wr_en(a_wr_en),
    .wr_addr(a_wr_addr), .wr_last_pass(a_last), .channel_idx(a_ch), .busy(a_busy), .done(a_done));
  accumulator_sequencer #(.IFM_SIZE_NEXT(2), .IFM_DEPTH(2), .ADDER_LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .conv_valid(conv_valid),
    .accu_enable(b_accu), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .wr_en(b_wr_en),
    .wr_addr(b_wr_addr), .wr_last_pass(b_last), .channel_idx(b_ch), .busy(b_busy), .done(b_done));
  accumulator_sequencer #(.IFM_SIZE_NEXT(10), .IFM_DEPTH(1), .ADDER_LATENCY(0)) dut_c (
    .clk(clk), .reset(reset), .start(start), .conv_valid(conv_valid),
    .accu_enable(c_accu), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .wr_en(c_wr_en),
    .wr_addr(c_wr_addr), .wr_last_pass(c_last), .channel_idx(c_ch), .busy(c_busy), .done(c_done));
  accumulator_sequencer #(.IFM_SIZE_NEXT(10), .IFM_DEPTH(1), .ADDER_LATENCY(3)) dut_d (
    .clk(clk), .reset(reset), .start(start), .conv_valid(conv_valid),
    .accu_enable(d_accu), .rd_en(d_rd_en), .rd_addr(d_rd_addr), .wr_en(d_wr_en),
    .wr_addr(d_wr_addr), .wr_last_pass(d_last), .channel_idx(d_ch), .busy(d_busy), .done(d_done));

  int o_accu, o_rd_en, o_rd_addr, o_wr_en, o_wr_addr, o_last, o_ch, o_busy, o_done;

  // Observed-instance mux
  always_comb begin
    o_accu = 0; o_rd_en = 0; o_rd_addr = 0; o_wr_en = 0; o_wr_addr = 0;
    o_last = 0; o_ch = 0; o_busy = 0; o_done = 0;
    case (sel)
      0: begin
        o_accu = int'(a_accu); o_rd_en = int'(a_rd_en); o_rd_addr = int'(a_rd_addr);
        o_wr_en = int'(a_wr_en); o_wr_addr = int'(a_wr_addr); o_last = int'(a_last);
        o_ch = int'(a_ch); o_busy = int'(a_busy); o_done = int'(a_done);
      end
      1: begin
        o_accu = int'(b_accu); o_rd_en = int'(b_rd_en); o_rd_addr = int'(b_rd_addr);
        o_wr_en = int'(b_wr_en); o_wr_addr = int'(b_wr_addr); o_last = int'(b_last);
        o_ch = int'(b_ch); o_busy = int'(b_busy); o_done = int'(b_done);
      end
      2: begin
        o_accu = int'(c_accu); o_rd_en = int'(c_rd_en); o_rd_addr = int'(c_rd_addr);
        o_wr_en = int'(c_wr_en); o_wr_addr = int'(c_wr_addr); o_last = int'(c_last);
        o_ch = int'(c_ch); o_busy = int'(c_busy); o_done = int'(c_done);
      end
      default: begin
        o_accu = int'(d_accu); o_rd_en = int'(d_rd_en); o_rd_addr = int'(d_rd_addr);
        o_wr_en = int'(d_wr_en); o_wr_addr = int'(d_wr_addr); o_last = int'(d_last);
        o_ch = int'(d_ch); o_busy = int'(d_busy); o_done = int'(d_done);
      end
    endcase
  end

  typedef struct {
    int due;
    int addr;
    int last;
  } wr_t;

  typedef struct {
    int cv;
    int rd_en;
    int rd_addr;
    int ch;
    int accu;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl [11];

  int n_tests = 0;
  int n_fail  = 0;
  int mon_en  = 0;
  int busy_cnt, done_cnt, wr_cnt, last_wr_cyc, done_cyc;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, sel %0d)", nm, act, exp, cyc, sel);
    end
  endtask

  task automatic push_wr(input int due, input int addr, input int last);
    wr_t e;
    e.due = due; e.addr = addr; e.last = last;
    sb.push_back(e);
  endtask

  // Write monitor / scoreboard checker
  always @(negedge clk) begin
    if (mon_en != 0) begin
      if (o_busy != 0) busy_cnt++;
      if (o_done != 0) begin done_cnt++; done_cyc = cyc; end
      if (o_busy == 0) begin
        chk("idle_rd_en", o_rd_en, 0);
        chk("idle_wr_en", o_wr_en, 0);
        chk("idle_accu", o_accu, 0);
      end
      if (o_wr_en != 0) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        chk("wr_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          wr_t e;
          e = sb.pop_front();
          chk("wr_addr", o_wr_addr, e.addr);
          chk("wr_last_pass", o_last, e.last);
          chk("wr_cycle", cyc, e.due);
        end
      end else if (sb.size() != 0 && sb[0].due < cyc) begin
        chk("wr_missing_cycle", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic drv(input logic cv, input logic st);
    @(posedge clk);
    #1;
    conv_valid = cv;
    start = st;
  endtask

  task automatic do_reset(input int s);
    mon_en = 0;
    @(posedge clk);
    #1;
    sel = s; reset = 1'b1; start = 1'b0; conv_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; last_wr_cyc = -100; done_cyc = -1;
    mon_en = 1;
    @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_accu", o_accu, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_rd_addr", o_rd_addr, 0);
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_wr_last", o_last, 0);
    chk("rst_channel", o_ch, 0);
  endtask

  task automatic end_checks(input int writes, input int busy_cycles, input int dones);
    chk("write_count", wr_cnt, writes);
    chk("busy_cycles", busy_cnt, busy_cycles);
    chk("done_count", done_cnt, dones);
    chk("sb_empty", sb.size(), 0);
    if (dones != 0) chk("done_after_last_wr", done_cyc, last_wr_cyc + 1);
  endtask

  // Full pass with junk: conv_valid in IDLE, start during RUN/FLUSH/DONE,
  // conv_valid during FLUSH/DONE. One idle RUN cycle precedes the pulses.
  task automatic run_pass(input int s, input int pix, input int depth, input int lat);
    int total;
    total = pix * depth;
    do_reset(s);
    repeat (3) begin
      drv(1'b1, 1'b0);
      @(negedge clk);
      chk("idle_cv_busy", o_busy, 0);
      chk("idle_cv_ch", o_ch, 0);
    end
    drv(1'b0, 1'b1);
    @(negedge clk);
    chk("start_cycle_busy", o_busy, 0);
    drv(1'b0, 1'b1);
    @(negedge clk);
    chk("gap_busy", o_busy, 1);
    chk("gap_accu", o_accu, 0);
    chk("gap_rd_addr", o_rd_addr, 0);
    for (int k = 0; k < total; k++) begin
      drv(1'b1, ((k % 7) == 3) ? 1'b1 : 1'b0);
      push_wr(cyc + lat, k % pix, int'((k / pix) == depth - 1));
      @(negedge clk);
      chk("run_accu", o_accu, int'(k >= pix));
      chk("run_rd_en", o_rd_en, int'(k >= pix));
      chk("run_rd_addr", o_rd_addr, k % pix);
      chk("run_channel", o_ch, k / pix);
      chk("run_busy", o_busy, 1);
    end
    for (int i = 0; i < lat; i++) begin
      drv(1'b1, 1'b1);
      @(negedge clk);
      chk("flush_busy", o_busy, 1);
      chk("flush_rd_en", o_rd_en, 0);
      chk("flush_channel", o_ch, 0);
    end
    drv(1'b1, 1'b1);
    @(negedge clk);
    chk("done_pulse", o_done, 1);
    chk("done_busy", o_busy, 0);
    repeat (3) begin
      drv(1'b1, 1'b0);
      @(negedge clk);
      chk("after_done_busy", o_busy, 0);
      chk("after_done_done", o_done, 0);
    end
    end_checks(total, 1 + total + lat, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Pass on 10x10x3 / latency 1, with ignored start and conv_valid
    run_pass(0, 100, 3, 1);

    // 2x2x2 with a three-cycle stall after the third pulse
    tbl[0]  = '{1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 2, 0, 0};
    tbl[3]  = '{0, 0, 3, 0, 0};
    tbl[4]  = '{0, 0, 3, 0, 0};
    tbl[5]  = '{0, 0, 3, 0, 0};
    tbl[6]  = '{1, 0, 3, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 1};
    tbl[8]  = '{1, 1, 1, 1, 1};
    tbl[9]  = '{1, 1, 2, 1, 1};
    tbl[10] = '{1, 1, 3, 1, 1};
    do_reset(1);
    drv(1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      drv(tbl[i].cv != 0, 1'b0);
      if (tbl[i].cv != 0) push_wr(cyc + 1, tbl[i].rd_addr, int'(tbl[i].ch == 1));
      @(negedge clk);
      chk("tbl_rd_en", o_rd_en, tbl[i].rd_en);
      chk("tbl_rd_addr", o_rd_addr, tbl[i].rd_addr);
      chk("tbl_channel", o_ch, tbl[i].ch);
      chk("tbl_accu", o_accu, tbl[i].accu);
      chk("tbl_busy", o_busy, 1);
    end
    drv(1'b0, 1'b0);
    @(negedge clk);
    chk("tbl_flush_busy", o_busy, 1);
    drv(1'b0, 1'b0);
    @(negedge clk);
    chk("tbl_done", o_done, 1);
    drv(1'b0, 1'b0);
    @(negedge clk);
    chk("tbl_idle_busy", o_busy, 0);
    end_checks(8, 12, 1);

    // Single channel, adder latency 0 and 3
    run_pass(2, 100, 1, 0);
    run_pass(3, 100, 1, 3);

    // Reset mid-run at channel 1 pixel 50, then restart
    do_reset(0);
    drv(1'b0, 1'b1);
    for (int k = 0; k < 150; k++) begin
      drv(1'b1, 1'b0);
      push_wr(cyc + 1, k % 100, 0);
      @(negedge clk);
      chk("pre_rst_rd_addr", o_rd_addr, k % 100);
      chk("pre_rst_channel", o_ch, k / 100);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    conv_valid = 1'b1;
    @(negedge clk);
    chk("rst_cycle_rd_addr", o_rd_addr, 50);
    chk("rst_cycle_channel", o_ch, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    conv_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", o_busy, 0);
    chk("post_rst_wr_en", o_wr_en, 0);
    chk("post_rst_rd_en", o_rd_en, 0);
    chk("post_rst_accu", o_accu, 0);
    chk("post_rst_channel", o_ch, 0);
    chk("post_rst_rd_addr", o_rd_addr, 0);
    chk("post_rst_done", o_done, 0);
    repeat (4) drv(1'b0, 1'b0);
    end_checks(150, 151, 0);
    drv(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b0);
      push_wr(cyc + 1, k, 0);
      @(negedge clk);
      chk("restart_rd_addr", o_rd_addr, k);
      chk("restart_channel", o_ch, 0);
      chk("restart_accu", o_accu, 0);
      chk("restart_rd_en", o_rd_en, 0);
    end
    repeat (2) drv(1'b0, 1'b0);
    @(negedge clk);
    chk("restart_sb_empty", sb.size(), 0);
    chk("restart_write_count", wr_cnt, 153);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
- Controls the bias/partial-sum accumulator for one convolution unit: counts conv results in raster order and tracks the input channel.
- Drives the accumulator mux select: bias on channel 0, stored partial sum on every later channel.
- Generates read/write strobes and addresses for the partial-sum (next-IFM) buffer, delaying the write to match the adder's latency.
- Sits between the conv engine's result stream and the next-layer IFM memory; one instance per unit, restarted for each filter group.

Parameters:
IFM_SIZE_NEXT, 10, output feature-map side; OFM_PIXELS = IFM_SIZE_NEXT*IFM_SIZE_NEXT
IFM_DEPTH, 3, input channels accumulated per output pixel
ADDER_LATENCY, 1, register stages between accumulator output and buffer write port; legal 0..4; OFM_PIXELS > ADDER_LATENCY required
ADDRESS_SIZE_NEXT_IFM, $clog2(OFM_PIXELS), buffer address width
NUMBER_OF_BITS_CHANNELS, $clog2(IFM_DEPTH)+1, channel counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  begin one accumulation pass (all channels, all pixels); honoured only in IDLE
conv_valid  input  1  conv result present on data_in_from_conv this cycle
accu_enable  output  1  0 = add bias, 1 = add data_in_from_next
rd_en  output  1  partial-sum buffer read strobe (combinational read)
rd_addr  output  ADDRESS_SIZE_NEXT_IFM  partial-sum read address
wr_en  output  1  partial-sum buffer write strobe
wr_addr  output  ADDRESS_SIZE_NEXT_IFM  partial-sum write address
wr_last_pass  output  1  qualifies wr_en: write belongs to final channel (result complete)
channel_idx  output  NUMBER_OF_BITS_CHANNELS  channel currently accumulated
busy  output  1  high in RUN and FLUSH
done  output  1  one-cycle pulse when last write has been issued

Behaviour:
- Reset: state IDLE; pixel_cnt, channel_idx, write pipeline valids and addresses cleared. All outputs 0 during and after reset until start.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE -> RUN on start. Counters are cleared on entry.
- RUN: rd_addr = pixel_cnt (combinational). rd_en = conv_valid && channel_idx != 0. accu_enable = (channel_idx != 0) whenever in RUN, independent of conv_valid.
- RUN, on each conv_valid:
  - pixel_cnt increments.
  - At pixel_cnt == OFM_PIXELS-1, pixel_cnt wraps to 0 and channel_idx increments.
  - At pixel_cnt == OFM_PIXELS-1 with channel_idx == IFM_DEPTH-1, go to FLUSH; channel_idx resets to 0.
  - A cycle without conv_valid holds all counters (stall).
- Write pipeline: a shift chain ADDER_LATENCY deep carries {valid = conv_valid, addr = pixel_cnt, last = channel_idx == IFM_DEPTH-1}. wr_en, wr_addr and wr_last_pass are the chain outputs.
  - ADDER_LATENCY = 0: writes occur in the same cycle as conv_valid (combinational).
  - The chain shifts every cycle in RUN and FLUSH; it does not stall.
- FLUSH: lasts exactly ADDER_LATENCY cycles (0 cycles if latency is 0), draining the chain; conv_valid is ignored. Then go to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy = 0 in DONE and IDLE.
- start outside IDLE is ignored. start asserted in the DONE cycle is also ignored.
- conv_valid in IDLE/DONE is ignored: no rd_en, no wr_en.
- Hazards: a pixel's partial sum is re-read only one full frame later, so with OFM_PIXELS > ADDER_LATENCY no read-after-write hazard exists and no bypass is implemented.
- reset mid-RUN or mid-FLUSH: in-flight writes are discarded (wr_en 0 the next cycle); done is not pulsed.
- IFM_DEPTH = 1: every write has wr_last_pass = 1, accu_enable stays 0, rd_en never asserts.

Test Plan:
1. Defaults, start, 300 back-to-back conv_valid pulses -> accu_enable = 0 for pulses 0-99 and 1 for pulses 100-299. wr_addr sequence 0..99 three times, each one cycle after its conv_valid. wr_last_pass on the last 100 writes only. done exactly 1 cycle after the last wr_en; busy 302 cycles.
2. IFM_SIZE_NEXT = 2, IFM_DEPTH = 2. conv_valid drops for 3 cycles after the 3rd pulse -> counters and rd_addr hold at 3. Total 8 writes; addresses 0,1,2,3,0,1,2,3; rd_en only on pulses 4-7.
3. ADDER_LATENCY = 0 vs 3, 100-pixel single channel (IFM_DEPTH = 1) -> latency 0: wr_en coincides with conv_valid and done follows the last write by 1 cycle. Latency 3: wr_en lags by 3 cycles. rd_en never high.
4. Assert reset after 150 pulses (channel 1, pixel 50) -> next cycle all outputs 0, no further wr_en, no done. A new start restarts at channel 0, pixel 0 with accu_enable = 0.
5. start pulsed during RUN and in the DONE cycle, conv_valid pulsed in IDLE -> no effect on counters; no rd_en or wr_en outside RUN/FLUSH.
